// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: channel FSM state
// encoding and default debounce/lockout lengths in 1 ms ticks.
package btn_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_LOCK = 3'd2;
  localparam logic [2:0] ST_HELD = 3'd3;
  localparam logic [2:0] ST_REL  = 3'd4;

  localparam int DEBOUNCE_MS_DEF = 10;
  localparam int LOCKOUT_MS_DEF  = 200;

endpackage

// File: rtl/btn_fsm.sv
// One button channel: debounce press, fire one pulse, hold off for the
// lockout window, then debounce the release before re-arming.
module btn_fsm import btn_pkg::*; #(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LOCKOUT_MS  = LOCKOUT_MS_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic tick,
  input  logic sync,
  output logic pulse,
  output logic level
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_MS - 1);
  localparam logic [7:0] LO_LAST = 8'(LOCKOUT_MS - 1);

  logic [2:0] state, nxt;
  logic [7:0] cnt, cnt_nxt;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if (!en) begin
      nxt     = ST_IDLE;
      cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (sync) nxt = ST_ARM;
        end
        ST_ARM: begin
          if (!sync) begin
            nxt     = ST_IDLE;
            cnt_nxt = '0;
          end else if (tick) begin
            if (cnt == DB_LAST) begin
              nxt     = ST_LOCK;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          end
        end
        // Input is deliberately ignored here so a held or bouncing button
        // cannot re-trigger inside the lockout window.
        ST_LOCK: begin
          if (tick) begin
            if (cnt == LO_LAST) begin
              nxt     = ST_HELD;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          end
        end
        ST_HELD: begin
          if (!sync) begin
            nxt     = ST_REL;
            cnt_nxt = '0;
          end
        end
        ST_REL: begin
          if (sync) begin
            nxt     = ST_HELD;
            cnt_nxt = '0;
          end else if (tick) begin
            if (cnt == DB_LAST) begin
              nxt     = ST_IDLE;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          end
        end
        default: begin
          nxt     = ST_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      pulse <= (state == ST_ARM) && (nxt == ST_LOCK);
      level <= (nxt == ST_LOCK) || (nxt == ST_HELD) || (nxt == ST_REL);
    end
  end

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner top: 2-FF synchroniser per button, shared 1 ms
// tick generator, and one debounce/lockout FSM per button.
module pb_conditioner import btn_pkg::*; #(
  parameter int NUM_BTN     = 5,
  parameter int TICK_DIV    = 100000,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LOCKOUT_MS  = LOCKOUT_MS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic [NUM_BTN-1:0] pb_raw,
  output logic [NUM_BTN-1:0] pb_pulse,
  output logic [NUM_BTN-1:0] pb_level
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  logic [1:0][NUM_BTN-1:0] sync_pipe;
  logic [TW-1:0]           tcnt;
  logic                    tick;

  always_ff @(posedge CLK) begin
    if (RST) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], pb_raw};
  end

  // tick is registered so it lands in the cycle where tcnt has wrapped to 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (tcnt == T_LAST);
      tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_fsm #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LOCKOUT_MS (LOCKOUT_MS)
    ) u_fsm (
      .CLK  (CLK),
      .RST  (RST),
      .en   (en),
      .tick (tick),
      .sync (sync_pipe[1][i]),
      .pulse(pb_pulse[i]),
      .level(pb_level[i])
    );
  end

endmodule
